psg_tone_bank: RTL and testbench

- Downstream stage of the PSG command decoder.
- Consumes per-channel strobes (enable, atten_enable) plus payloads (freq, atten_mag), and holds three tone channels' frequency and attenuation registers.
- Generates three square waves and mixes them into one registered amplitude sample for the audio DAC/PWM stage.

---
 rtl/psg_pkg.sv | 25 ++
 rtl/psg_tone_channel.sv | 59 +++++
 rtl/psg_tone_bank.sv | 105 ++++++++++
 tb/tb_psg_tone_bank.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared constants, volume table and per-channel state type for the PSG tone bank.
package psg_pkg;

    localparam int NUM_CH  = 3;
    localparam int FREQ_W  = 10;
    localparam int ATTEN_W = 4;

    // Index 0 (loudest) sits in the least-significant byte; 2 dB per attenuation step.
    localparam logic [15:0][7:0] VOL_TABLE = {
        8'd0,   8'd10,  8'd13,  8'd16,  8'd20,  8'd26,  8'd32,  8'd40,
        8'd51,  8'd64,  8'd81,  8'd102, 8'd128, 8'd161, 8'd203, 8'd255
    };

    typedef struct packed {
        logic [FREQ_W-1:0]  freq_reg;
        logic [ATTEN_W-1:0] atten_reg;
        logic [FREQ_W-1:0]  counter;
        logic               polarity;
    } tone_ch_t;

    function automatic logic [7:0] vol_lookup(input logic [ATTEN_W-1:0] atten);
        return VOL_TABLE[atten];
    endfunction

endpackage

// File: rtl/psg_tone_channel.sv
// One tone channel: frequency/attenuation registers, half-period counter,
// square-wave polarity and amplitude lookup.
module psg_tone_channel
    import psg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               wr_freq,
    input  logic [FREQ_W-1:0]  freq,
    input  logic               wr_atten,
    input  logic [ATTEN_W-1:0] atten_mag,
    output logic               tone,
    output logic [7:0]         amp
);

    tone_ch_t          ch_reg;
    tone_ch_t          ch_next;
    logic [FREQ_W-1:0] eff_freq;

    // A write landing on the tick cycle is seen by that tick's reload.
    assign eff_freq = wr_freq ? freq : ch_reg.freq_reg;

    always_comb begin
        ch_next = ch_reg;
        if (tick) begin
            if (eff_freq <= FREQ_W'(1)) begin
                ch_next.counter  = '0;
                ch_next.polarity = 1'b1;
            end else if (ch_reg.counter == '0) begin
                ch_next.counter  = eff_freq - FREQ_W'(1);
                ch_next.polarity = ~ch_reg.polarity;
            end else begin
                ch_next.counter  = ch_reg.counter - FREQ_W'(1);
            end
        end
        if (wr_freq) begin
            ch_next.freq_reg = freq;
        end
        if (wr_atten) begin
            ch_next.atten_reg = atten_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_reg.freq_reg  <= '0;
            ch_reg.atten_reg <= '1;
            ch_reg.counter   <= '0;
            ch_reg.polarity  <= 1'b0;
        end else begin
            ch_reg <= ch_next;
        end
    end

    assign tone = ch_reg.polarity;
    assign amp  = vol_lookup(ch_reg.atten_reg);

endmodule

// File: rtl/psg_tone_bank.sv
// Three-channel PSG tone generator with prescaler and registered mixer.
// Optional PSG_BIPOLAR_EN: signed SAMPLE_W+1 output, channels contribute +amp/-amp.
module psg_tone_bank
    import psg_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int SAMPLE_W = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 enable,
    input  logic [9:0]                 freq,
    input  logic [2:0]                 atten_enable,
    input  logic [3:0]                 atten_mag,
    output logic [2:0]                 tone_out,
`ifdef PSG_BIPOLAR_EN
    output logic signed [SAMPLE_W:0]   sample,
`else
    output logic [SAMPLE_W-1:0]        sample,
`endif
    output logic                       sample_valid
);

`ifdef PSG_BIPOLAR_EN
    localparam int MIX_W = SAMPLE_W + 1;
`else
    localparam int MIX_W = SAMPLE_W;
`endif
    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0]   prescale_reg;
    logic              tick;
    logic              tick_d_reg;
    logic [NUM_CH-1:0] tone_w;
    logic [7:0]        amp_w [NUM_CH];
    logic [MIX_W-1:0]  mix_next;
    logic [MIX_W-1:0]  sample_reg;
    logic              sample_valid_reg;

    assign tick = (prescale_reg == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_reg <= '0;
        end else if (tick) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + PS_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            psg_tone_channel u_ch (
                .clk       (clk),
                .reset     (reset),
                .tick      (tick),
                .wr_freq   (enable[gi]),
                .freq      (freq),
                .wr_atten  (atten_enable[gi]),
                .atten_mag (atten_mag),
                .tone      (tone_w[gi]),
                .amp       (amp_w[gi])
            );
        end
    endgenerate

    // Mix runs the cycle after a tick, so it sees the updated polarity but
    // attenuation as registered before any write in that same cycle.
    always_comb begin
        mix_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef PSG_BIPOLAR_EN
            if (tone_w[i]) begin
                mix_next = mix_next + MIX_W'(amp_w[i]);
            end else begin
                mix_next = mix_next - MIX_W'(amp_w[i]);
            end
`else
            if (tone_w[i]) begin
                mix_next = mix_next + MIX_W'(amp_w[i]);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_d_reg       <= 1'b0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
        end else begin
            tick_d_reg       <= tick;
            sample_valid_reg <= tick_d_reg;
            if (tick_d_reg) begin
                sample_reg <= mix_next;
            end
        end
    end

    assign tone_out     = tone_w;
    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_psg_tone_bank.sv
// Self-checking bench for psg_tone_bank: tick-level behavioural model plus
// directed literal checks; also builds with PSG_BIPOLAR_EN.
module tb_psg_tone_bank;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  enable;
    logic [9:0]  freq;
    logic [2:0]  atten_enable;
    logic [3:0]  atten_mag;
    logic [2:0]  tone_out;
`ifdef PSG_BIPOLAR_EN
    logic signed [10:0] sample;
    localparam int LO_255 = -255;
`else
    logic [9:0]  sample;
    localparam int LO_255 = 0;
`endif
    logic        sample_valid;

    always #5 clk = ~clk;

    psg_tone_bank #(.PRESCALE(P), .SAMPLE_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .freq         (freq),
        .atten_enable (atten_enable),
        .atten_mag    (atten_mag),
        .tone_out     (tone_out),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    int vol [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};

    // Model: m_dl is the tick index at which the channel next flips.
    int m_freq [3];
    int m_atten [3];
    int m_tone [3];
    int m_dl [3];
    int m_pc, m_n, m_sample;
    bit m_pend, m_valid, live;
    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int contrib(input int t, input int a);
`ifdef PSG_BIPOLAR_EN
        return (t != 0) ? vol[a] : -vol[a];
`else
        return (t != 0) ? vol[a] : 0;
`endif
    endfunction

    function automatic int dut_sample();
`ifdef PSG_BIPOLAR_EN
        return int'($signed(sample));
`else
        return int'(sample);
`endif
    endfunction

    function automatic int model_tone();
        return m_tone[0] | (m_tone[1] << 1) | (m_tone[2] << 2);
    endfunction

    task automatic model_step();
        int eff;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_freq[i] = 0; m_atten[i] = 15; m_tone[i] = 0; m_dl[i] = 0;
            end
            m_pc = 0; m_n = 0; m_pend = 0; m_sample = 0; m_valid = 0;
            live = 1;
        end else begin
            m_valid = m_pend;
            if (m_pend) begin
                m_sample = 0;
                for (int i = 0; i < 3; i++) m_sample += contrib(m_tone[i], m_atten[i]);
            end
            m_pend = ((m_pc % P) == P - 1);
            if (m_pend) begin
                for (int i = 0; i < 3; i++) begin
                    eff = enable[i] ? int'(freq) : m_freq[i];
                    if (eff <= 1) begin
                        m_tone[i] = 1;
                        m_dl[i] = m_n + 1;
                    end else if (m_n >= m_dl[i]) begin
                        m_tone[i] = 1 - m_tone[i];
                        m_dl[i] = m_n + eff;
                    end
                end
                m_n++;
            end
            for (int i = 0; i < 3; i++) begin
                if (enable[i]) m_freq[i] = int'(freq);
                if (atten_enable[i]) m_atten[i] = int'(atten_mag);
            end
            m_pc++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        enable = 3'b000; freq = 10'd0; atten_enable = 3'b000; atten_mag = 4'd0;
    endtask

    task automatic wr(input int ch, input int f, input int a);
        enable = 3'b001 << ch; freq = 10'(f);
        atten_enable = (a >= 0) ? (3'b001 << ch) : 3'b000;
        atten_mag = 4'(a < 0 ? 0 : a);
        cycle();
        idle();
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("tone_out", int'(tone_out), model_tone());
            chk("sample_valid", int'(sample_valid), int'(m_valid));
            chk("sample", dut_sample(), m_sample);
        end
    end

    initial begin
        int first, second, ta, tb, prev, bad, s, found;
        bit saw_hi, saw_lo, saw_peak;
        live = 0;
        reset = 1'b1;
        idle();
        @(negedge clk);

        repeat (3) cycle();
        chk("reset_tone", int'(tone_out), 0);
        chk("reset_sample", dut_sample(), 0);
        chk("reset_valid", int'(sample_valid), 0);
        reset = 1'b0;

        first = -1; second = -1;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (sample_valid) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        chk("valid_period", second - first, 16);

        wr(0, 4, 0);
        ta = -1; tb = -1; prev = tone_out[0]; saw_hi = 0; saw_lo = 0; bad = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (int'(tone_out[0]) != prev) begin
                if (ta < 0) ta = cyc; else if (tb < 0) tb = cyc;
                prev = tone_out[0];
            end
            if (sample_valid) begin
                s = dut_sample();
                if (s == 255) saw_hi = 1;
                else if (s == LO_255) saw_lo = 1;
                else bad++;
            end
        end
        chk("basic_half_period", tb - ta, 64);
        chk("basic_saw_255", int'(saw_hi), 1);
        chk("basic_saw_low", int'(saw_lo), 1);
        chk("basic_bad_samples", bad, 0);

        wr(0, 4, 15);
        wr(1, 1, 0);
        repeat (40) cycle();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (tone_out[1] !== 1'b1) bad++;
            if (sample_valid && dut_sample() != 255) bad++;
        end
        chk("dc_bad_cycles", bad, 0);

        reset = 1'b1; cycle(); reset = 1'b0;
        wr(0, 4, 0);
        wr(1, 8, 3);
        wr(2, 2, 15);
        bad = 0; saw_peak = 0;
        for (int i = 0; i < 1200; i++) begin
            cycle();
            if (sample_valid) begin
                s = dut_sample();
`ifdef PSG_BIPOLAR_EN
                if (!(s == -383 || s == -127 || s == 127 || s == 383)) bad++;
`else
                if (!(s == 0 || s == 128 || s == 255 || s == 383)) bad++;
`endif
                if (s == 383) saw_peak = 1;
            end
        end
        chk("mix_bad_samples", bad, 0);
        chk("mix_saw_383", int'(saw_peak), 1);

        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if ((m_pc % P) == P - 1 && m_dl[0] <= m_n) begin
                enable = 3'b001; freq = 10'd6; found = 1;
            end
            cycle();
            idle();
        end
        chk("bypass_found", found, 1);
        ta = cyc; prev = tone_out[0]; tb = -1;
        for (int i = 0; i < 200 && tb < 0; i++) begin
            cycle();
            if (int'(tone_out[0]) != prev) tb = cyc;
        end
        chk("bypass_half_period", tb - ta, 96);

        reset = 1'b1; cycle(); reset = 1'b0;
        wr(0, 3, 0);
        wr(1, 5, -1);
        wr(2, 7, 0);
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            if (model_tone() == 5 && m_sample == 510) found = 1;
            else cycle();
        end
        chk("midtone_found", found, 1);
        chk("midtone_sample", dut_sample(), 510);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("midreset_tone", int'(tone_out), 0);
        chk("midreset_sample", dut_sample(), 0);
        chk("midreset_valid", int'(sample_valid), 0);
        repeat (40) cycle();
        chk("postreset_dc_tone", int'(tone_out), 7);
        chk("postreset_sample", dut_sample(), 0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            enable = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            freq = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                               : 10'($urandom_range(0, 8));
            atten_enable = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            atten_mag = 4'($urandom_range(0, 15));
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
